calc_result_reader: RTL
=======================

Name: calc_result_reader

Overview:
Consumer end of the calculator's result stream. It captures a frame of 16 {NEG, RESULT} pairs, one per executed instruction, into a local buffer. It then drains the frame to a downstream consumer over a valid/ready handshake, and reports a per-frame negative-result count and a sticky drop flag. It sits directly after the calculator's ALU outputs.

Parameters:
DATA_W, 16, width of one result word
DEPTH, 16, results per frame; equals calculator instruction memory depth
IDX_W, 4, index width, log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
res_valid  input  1  result pair present this cycle
res_data  input  DATA_W  ALU result magnitude
res_neg  input  1  ALU negative flag
out_valid  output  1  out_* fields hold a valid entry
out_ready  input  1  downstream accepts the entry
out_data  output  DATA_W  buffered result
out_neg  output  1  buffered negative flag
out_index  output  IDX_W  slot index of the presented entry (0..15)
out_last  output  1  high with entry 15
neg_count  output  IDX_W+1  negative results in the current frame (0..16)
busy  output  1  high in DRAIN
dropped  output  1  sticky: a result arrived while draining

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset: all of the following clear to 0: outputs, wr_ptr, rd_ptr, neg_count, dropped, and every buffer entry. State becomes CAPTURE.
- Reset asserted mid-frame or mid-drain: partial data is discarded and capture restarts at slot 0.
- States: CAPTURE and DRAIN only.
- CAPTURE:
  - On each clk edge with res_valid=1, write {res_neg,res_data} to buf[wr_ptr], then increment wr_ptr.
  - If res_neg=1, increment neg_count.
  - out_valid=0 and busy=0.
  - On the write to slot DEPTH-1: wr_ptr wraps to 0 and the state moves to DRAIN. out_valid rises on the next cycle, giving 1-cycle latency from the 16th capture.
- DRAIN:
  - out_valid=1 and busy=1.
  - out_data, out_neg and out_index reflect buf[rd_ptr]. They are stable while out_valid=1 and out_ready=0.
  - On a handshake (out_valid & out_ready), rd_ptr increments.
  - out_last=1 exactly when rd_ptr=DEPTH-1.
  - The handshake on the last entry wraps rd_ptr to 0, clears neg_count, and returns the state to CAPTURE. out_valid is 0 the next cycle.
  - neg_count holds its final frame value throughout DRAIN.
- Drop rule:
  - Any res_valid=1 sampled in DRAIN is discarded and sets dropped=1.
  - This includes the cycle of the last handshake, because state is evaluated at the edge.
  - dropped clears only on reset.
- Arithmetic:
  - Pointers wrap modulo DEPTH.
  - neg_count is unsigned and cannot exceed DEPTH, so it never overflows.
  - res_data is stored unmodified; there is no sign extension.
- Throughput: one result per cycle in CAPTURE; one entry per cycle in DRAIN when out_ready is held high.
- Minimum frame turnaround: 16 capture cycles plus 16 drain cycles.
- Stalls: out_ready=0 stalls the drain indefinitely, with no timeout. Combined with the drop rule, the upstream calculator must not issue results while busy=1.

Decomposition:
- Shared package calc_pkg holds:
  - DATA_W, DEPTH and IDX_W constants, shared with the calculator.
  - A state typedef with values CAPTURE and DRAIN.
  - A result_t typedef: packed {neg, data}.
- One sub-module, calc_result_buf:
  - DEPTH x (DATA_W+1) register file.
  - One synchronous write port and one combinational read port.
  - Asynchronous clear on reset.
- The FSM, pointers, neg_count and dropped live in calc_result_reader.

Test Plan:
- Reset then 16 consecutive results with res_data=i*3 and res_neg=(i odd) -> out_valid rises 1 cycle after the 16th capture. With out_ready held high, the outputs are out_index 0..15, out_data 0,3,...,45, out_neg alternating 0/1, out_last only at index 15, and neg_count=8 throughout the drain.
- Backpressure: out_ready toggles 1,0,0,1,... -> each entry is held stable while out_ready=0. Entries are never duplicated or skipped, and exactly 16 handshakes occur.
- Drop: res_valid=1 with 0xBEEF at drain index 5 -> dropped=1, the frame contents are unchanged, and the next frame starts at slot 0 with neg_count=0.
- Gapped capture: res_valid high on alternate cycles, all res_neg=1 -> DRAIN entered only after the 16th valid result, and neg_count=16.
- Reset mid-drain at index 7 -> the same cycle shows out_valid=0, busy=0, neg_count=0 and dropped=0. A following 16-result frame drains correctly starting from index 0.
- Back-to-back frames: frame A values 0x0001..0x0010, then frame B values 0xFFF0..0xFFFF with res_valid asserted the cycle after A's last handshake -> B is captured fully with no drop, and drains in order.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator result path.
// The reader and the calculator both size their memories from DEPTH.
package calc_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    CAPTURE = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  typedef struct packed {
    logic              neg;
    logic [DATA_W-1:0] data;
  } result_t;

endpackage

// File: rtl/calc_result_buf.sv
// Frame buffer: DEPTH result entries.
// Synchronous write, combinational read, cleared asynchronously on reset.
module calc_result_buf
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  result_t          wdata,
  input  logic [IDX_W-1:0] raddr,
  output result_t          rdata
);

  result_t mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/calc_result_reader.sv
// Captures a 16-entry frame of ALU results, then drains it downstream while
// counting negative results and flagging any result that arrives mid-drain.
module calc_result_reader
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_neg,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic [IDX_W:0]    neg_count,
  output logic              busy,
  output logic              dropped
);

  // Handshake: an entry transfers on a rising clk edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and the
  // out_* fields hold still until the transfer happens.

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W:0]   neg_count_q, neg_count_d;
  logic             dropped_q, dropped_d;
  logic             buf_we;
  result_t          wr_entry;
  result_t          rd_entry;

  assign wr_entry.neg  = res_neg;
  assign wr_entry.data = res_data;

  calc_result_buf u_buf (
    .clk   (clk),
    .rst   (reset),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CAPTURE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      neg_count_q <= '0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      neg_count_q <= neg_count_d;
      dropped_q   <= dropped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    neg_count_d = neg_count_q;
    dropped_d   = dropped_q;
    buf_we      = 1'b0;
    case (state_q)
      CAPTURE: begin
        if (res_valid) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + IDX_W'(1);
          if (res_neg) begin
            neg_count_d = neg_count_q + (IDX_W + 1)'(1);
          end
          if (wr_ptr_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Results are never buffered while draining; the upstream must wait on busy.
        if (res_valid) begin
          dropped_d = 1'b1;
        end
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + IDX_W'(1);
          if (rd_ptr_q == LAST_IDX) begin
            neg_count_d = '0;
            state_d     = CAPTURE;
          end
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  // Data fields are zeroed outside DRAIN so stale frames never leak out.
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_data  = out_valid ? rd_entry.data : '0;
  assign out_neg   = out_valid & rd_entry.neg;
  assign out_index = rd_ptr_q;
  assign out_last  = out_valid & (rd_ptr_q == LAST_IDX);
  assign neg_count = neg_count_q;
  assign dropped   = dropped_q;

endmodule
